// File: rtl/send_scheduler_if.sv
// send_scheduler_if: groups the scheduler's control inputs and its pulse/status outputs.
// master = the environment (packet builder, senders, decoder); slave = the scheduler.
interface send_scheduler_if;
    logic        game_active;
    logic        update_req;
    logic        send_done;
    logic        ack_received;
    logic        ack_req;
    logic        lost_req;
    logic        hnd_busy;
    logic        update_data;
    logic        send_start;
    logic        hnd_ack_start;
    logic        hnd_lost_start;
    logic        seq_num;
    logic [3:0]  retry_cnt;
    logic        link_fail;
    logic [15:0] retx_total;

    modport master (
        output game_active, update_req, send_done, ack_received,
               ack_req, lost_req, hnd_busy,
        input  update_data, send_start, hnd_ack_start, hnd_lost_start,
               seq_num, retry_cnt, link_fail, retx_total
    );

    modport slave (
        input  game_active, update_req, send_done, ack_received,
               ack_req, lost_req, hnd_busy,
        output update_data, send_start, hnd_ack_start, hnd_lost_start,
               seq_num, retry_cnt, link_fail, retx_total
    );
endinterface

// File: rtl/send_scheduler.sv
// send_scheduler: data-packet send / ACK-wait / retransmit FSM plus an independent handshake-line arbiter.
// Optional define SEND_SCHED_STATS_EN adds a saturating retransmit counter on retx_total (tied to 0 otherwise).
module send_scheduler #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int MAX_RETRIES    = 3
) (
    input logic             clk,
    input logic             rst_l,
    send_scheduler_if.slave bus
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] MAX_RETRY_L  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START    = 3'd2,
        SENDING  = 3'd3,
        WAIT_ACK = 3'd4,
        FAIL     = 3'd5
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        pending_r;
    logic [7:0]  timer_r;
    logic        seq_r;
    logic [3:0]  retry_r;
    logic        link_fail_r;
    logic        update_data_s;
    logic        timeout_s;
    logic        ack_win_s;
    logic        retx_s;
    logic        fail_s;

    logic        ack_pend_r;
    logic        lost_pend_r;
    logic        ack_start_r;
    logic        lost_start_r;
    logic        hnd_free_s;
    logic        grant_ack_s;
    logic        grant_lost_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

    // WAIT_ACK outcome flags; an ACK beats a coincident timeout, and an inactive game overrides both
    always_comb begin
        timeout_s = (timer_r == TIMEOUT_LAST);
        ack_win_s = 1'b0;
        retx_s    = 1'b0;
        fail_s    = 1'b0;
        if (bus.game_active && (state_r == WAIT_ACK)) begin
            ack_win_s = bus.ack_received;
            retx_s    = !bus.ack_received && timeout_s && (retry_r < MAX_RETRY_L);
            fail_s    = !bus.ack_received && timeout_s && !(retry_r < MAX_RETRY_L);
        end else begin
            ack_win_s = 1'b0;
        end
    end

    // Data FSM next-state and update_data decode
    always_comb begin
        next_state_s  = state_r;
        update_data_s = 1'b0;
        if (!bus.game_active) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pending_r) begin
                        update_data_s = 1'b1;
                        next_state_s  = LOAD;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                LOAD:    next_state_s = START;
                START:   next_state_s = SENDING;
                SENDING: begin
                    if (bus.send_done) begin
                        next_state_s = WAIT_ACK;
                    end else begin
                        next_state_s = SENDING;
                    end
                end
                WAIT_ACK: begin
                    if (ack_win_s) begin
                        next_state_s = IDLE;
                    end else if (retx_s) begin
                        next_state_s = START;
                    end else if (fail_s) begin
                        next_state_s = FAIL;
                    end else begin
                        next_state_s = WAIT_ACK;
                    end
                end
                FAIL:    next_state_s = FAIL;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Data FSM state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Pending request, ACK timer, retry count and sticky link failure; seq_num survives a game stop
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pending_r   <= 1'b0;
            timer_r     <= 8'd0;
            seq_r       <= 1'b0;
            retry_r     <= 4'd0;
            link_fail_r <= 1'b0;
        end else if (!bus.game_active) begin
            pending_r   <= 1'b0;
            timer_r     <= 8'd0;
            retry_r     <= 4'd0;
            link_fail_r <= 1'b0;
        end else begin
            pending_r <= update_data_s ? 1'b0 : (pending_r | bus.update_req);
            timer_r   <= (state_r == WAIT_ACK) ? (timer_r + 8'd1) : 8'd0;
            if (ack_win_s) begin
                seq_r   <= ~seq_r;
                retry_r <= 4'd0;
            end else if (retx_s) begin
                retry_r <= retry_r + 4'd1;
            end else begin
                retry_r <= retry_r;
            end
            link_fail_r <= link_fail_r | fail_s;
        end
    end

    // Handshake grant: line idle and no start in the previous cycle; lost wins over ack
    always_comb begin
        hnd_free_s   = !bus.hnd_busy && !ack_start_r && !lost_start_r;
        grant_lost_s = hnd_free_s && lost_pend_r;
        grant_ack_s  = hnd_free_s && ack_pend_r && !lost_pend_r;
    end

    // Handshake pending bits and registered start pulses, independent of game_active
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ack_pend_r   <= 1'b0;
            lost_pend_r  <= 1'b0;
            ack_start_r  <= 1'b0;
            lost_start_r <= 1'b0;
        end else begin
            ack_pend_r   <= bus.ack_req  | (ack_pend_r  & ~grant_ack_s);
            lost_pend_r  <= bus.lost_req | (lost_pend_r & ~grant_lost_s);
            ack_start_r  <= grant_ack_s;
            lost_start_r <= grant_lost_s;
        end
    end

`ifdef SEND_SCHED_STATS_EN
    logic [15:0] retx_total_r;

    // Lifetime retransmit count; only a hard reset clears it
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            retx_total_r <= 16'd0;
        end else if (retx_s) begin
            retx_total_r <= sat_inc16(retx_total_r);
        end else begin
            retx_total_r <= retx_total_r;
        end
    end

    assign bus.retx_total = retx_total_r;
`else
    assign bus.retx_total = 16'h0000;
`endif

    assign bus.update_data    = update_data_s;
    assign bus.send_start     = (state_r == START);
    assign bus.hnd_ack_start  = ack_start_r;
    assign bus.hnd_lost_start = lost_start_r;
    assign bus.seq_num        = seq_r;
    assign bus.retry_cnt      = retry_r;
    assign bus.link_fail      = link_fail_r;

endmodule

// File: tb/tb_send_scheduler.sv
// Scoreboard bench for send_scheduler (TIMEOUT_CYCLES=8, MAX_RETRIES=2): stimulus queues expected
// pulse cycles and status snapshots; a negedge monitor is the only process that compares.
module tb_send_scheduler;

    logic clk = 1'b0;
    logic rst_l;
    int   cyc = 0;

    send_scheduler_if bus_if ();

    send_scheduler #(
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        seq;
        logic [3:0]  retry;
        logic        fail;
        logic [15:0] retx;
    } stat_t;

    // 0 update_data, 1 send_start, 2 hnd_ack_start, 3 hnd_lost_start
    int    q_pulse [4][$];
    stat_t q_stat[$];
    string pulse_name [4] = '{"update_data", "send_start", "hnd_ack_start", "hnd_lost_start"};

    int   checks_n = 0;
    int   errors_n = 0;
    bit   done = 1'b0;
    logic seq_model = 1'b0;
    int   retx_model = 0;

    always @(negedge clk) begin
        logic [3:0] seen;
        int         e;
        stat_t      s;
        seen = {bus_if.hnd_lost_start, bus_if.hnd_ack_start, bus_if.send_start, bus_if.update_data};
        for (int k = 0; k < 4; k++) begin
            if (seen[k]) begin
                checks_n++;
                if (q_pulse[k].size() == 0) begin
                    errors_n++;
                    $display("FAIL %s: pulse at cycle %0d, none expected", pulse_name[k], cyc);
                end else begin
                    e = q_pulse[k].pop_front();
                    if (e != cyc) begin
                        errors_n++;
                        $display("FAIL %s: pulse at cycle %0d, expected at cycle %0d", pulse_name[k], cyc, e);
                    end
                end
            end else if (q_pulse[k].size() > 0 && q_pulse[k][0] <= cyc) begin
                checks_n++;
                errors_n++;
                e = q_pulse[k].pop_front();
                $display("FAIL %s: no pulse at cycle %0d, expected at cycle %0d", pulse_name[k], cyc, e);
            end
        end
        if (q_stat.size() > 0 && q_stat[0].cyc <= cyc) begin
            s = q_stat.pop_front();
            checks_n++;
            if (s.cyc != cyc || bus_if.seq_num !== s.seq || bus_if.retry_cnt !== s.retry ||
                bus_if.link_fail !== s.fail || bus_if.retx_total !== s.retx) begin
                errors_n++;
                $display("FAIL status@%0d: got seq=%0b retry=%0d link_fail=%0b retx=%0d, expected seq=%0b retry=%0d link_fail=%0b retx=%0d",
                         cyc, bus_if.seq_num, bus_if.retry_cnt, bus_if.link_fail, bus_if.retx_total,
                         s.seq, s.retry, s.fail, s.retx);
            end
        end
        if (done) begin
            for (int k = 0; k < 4; k++) begin
                checks_n++;
                if (q_pulse[k].size() != 0) begin
                    errors_n++;
                    $display("FAIL %s leftover: %0d expected pulses never seen, required 0", pulse_name[k], q_pulse[k].size());
                end
            end
            checks_n++;
            if (q_stat.size() != 0) begin
                errors_n++;
                $display("FAIL status leftover: %0d snapshots unchecked, required 0", q_stat.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
            $finish;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_stat(input int c, input logic [3:0] retry, input logic fail);
        stat_t s;
        s.cyc   = c;
        s.seq   = seq_model;
        s.retry = retry;
        s.fail  = fail;
`ifdef SEND_SCHED_STATS_EN
        s.retx  = 16'(retx_model);
`else
        s.retx  = 16'h0000;
`endif
        q_stat.push_back(s);
    endtask

    // update_req in cycle c: update_data at c+1, send_start at c+3, WAIT_ACK from c+5
    task automatic start_packet(output int c);
        c = cyc;
        bus_if.update_req = 1'b1;
        q_pulse[0].push_back(c + 1);
        q_pulse[1].push_back(c + 3);
        wait_cyc(c + 1);
        bus_if.update_req = 1'b0;
    endtask

    task automatic pulse_ack(input int at);
        wait_cyc(at);
        bus_if.ack_received = 1'b1;
        wait_cyc(at + 1);
        bus_if.ack_received = 1'b0;
    endtask

    // Each retransmit costs 10 cycles with send_done high (8 wait + START + SENDING)
    task automatic run_packet(input int n_retx);
        int c;
        start_packet(c);
        for (int k = 1; k <= n_retx; k++) begin
            q_pulse[1].push_back(c + 3 + 10 * k);
            retx_model++;
            push_stat(c + 3 + 10 * k, 4'(k), 1'b0);
        end
        pulse_ack(c + 5 + 10 * n_retx);
        seq_model = ~seq_model;
        push_stat(c + 6 + 10 * n_retx, 4'd0, 1'b0);
        wait_cyc(c + 8 + 10 * n_retx);
    endtask

    initial begin
        int c;
        int e;
        int h;
        int r;
        rst_l               = 1'b0;
        bus_if.game_active  = 1'b1;
        bus_if.update_req   = 1'b0;
        bus_if.send_done    = 1'b1;
        bus_if.ack_received = 1'b0;
        bus_if.ack_req      = 1'b0;
        bus_if.lost_req     = 1'b0;
        bus_if.hnd_busy     = 1'b0;
        push_stat(1, 4'd0, 1'b0);
        wait_cyc(2);
        rst_l = 1'b1;
        push_stat(3, 4'd0, 1'b0);
        wait_cyc(4);

        // basic send + ACK: seq 0 -> 1
        run_packet(0);

        // ACK coinciding with the 8th WAIT_ACK cycle wins: no retransmit
        start_packet(c);
        pulse_ack(c + 12);
        seq_model = ~seq_model;
        push_stat(c + 13, 4'd0, 1'b0);
        wait_cyc(c + 16);

        // no ACK: two retransmits, then link_fail held in FAIL
        start_packet(c);
        q_pulse[1].push_back(c + 13);
        q_pulse[1].push_back(c + 23);
        retx_model++;
        push_stat(c + 13, 4'd1, 1'b0);
        retx_model++;
        push_stat(c + 23, 4'd2, 1'b0);
        push_stat(c + 33, 4'd2, 1'b1);
        push_stat(c + 40, 4'd2, 1'b1);
        wait_cyc(c + 41);
        bus_if.game_active = 1'b0;
        push_stat(c + 42, 4'd0, 1'b0);
        wait_cyc(c + 43);
        bus_if.game_active = 1'b1;
        bus_if.send_done   = 1'b0;

        // game stop while SENDING drops the packet and the pending request
        start_packet(e);
        wait_cyc(e + 5);
        bus_if.update_req = 1'b1;
        wait_cyc(e + 6);
        bus_if.update_req  = 1'b0;
        bus_if.game_active = 1'b0;
        push_stat(e + 7, 4'd0, 1'b0);

        // handshake arbitration with the game stopped: lost first, ack after busy falls
        wait_cyc(e + 8);
        h = cyc;
        bus_if.ack_req  = 1'b1;
        bus_if.lost_req = 1'b1;
        q_pulse[3].push_back(h + 2);
        q_pulse[2].push_back(h + 8);
        wait_cyc(h + 1);
        bus_if.ack_req  = 1'b0;
        bus_if.lost_req = 1'b0;
        wait_cyc(h + 3);
        bus_if.hnd_busy = 1'b1;
        wait_cyc(h + 7);
        bus_if.hnd_busy = 1'b0;
        wait_cyc(h + 10);
        bus_if.game_active = 1'b1;
        bus_if.send_done   = 1'b1;
        wait_cyc(h + 17);

        // reset during SENDING: everything clears, no pulses afterwards
        start_packet(r);
        wait_cyc(r + 4);
        rst_l      = 1'b0;
        seq_model  = 1'b0;
        retx_model = 0;
        wait_cyc(r + 6);
        rst_l = 1'b1;
        push_stat(r + 7, 4'd0, 1'b0);
        wait_cyc(r + 16);

        // five retransmits total across three acknowledged packets
        run_packet(2);
        run_packet(2);
        run_packet(1);

        wait_cyc(cyc + 4);
        done = 1'b1;
    end

endmodule
